// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: shared types and constants for the RAM loader slice.
//   state_t   - loader FSM states
//   LANE_W    - width of one byte lane
//   BYTES     - byte lanes per word at the default 32-bit word width
//   bytes_of  - byte lanes per word for any word width (multiple of 8)
package ram_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    VERIFY,
    CHECK,
    DONE
  } state_t;

  localparam int LANE_W             = 8;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int BYTES              = DEFAULT_DATA_WIDTH / LANE_W;

  function automatic int bytes_of(input int data_width);
    return data_width / LANE_W;
  endfunction

endpackage

// File: rtl/ram_loader_if.sv
// ram_loader_if: byte-stream handshake plus the RAM clk-domain port.
//   in_valid/in_data/in_ready        - byte stream (valid/ready)
//   ram_wEn/ram_addr/ram_dataIn      - RAM write/read request
//   ram_dataOut                      - RAM registered read data
// Modports: slave = the loader's view, master = the feeder/RAM side.
interface ram_loader_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
) ();

  logic                     in_valid;
  logic [7:0]               in_data;
  logic                     in_ready;
  logic                     ram_wEn;
  logic [ADDRESS_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0]    ram_dataIn;
  logic [DATA_WIDTH-1:0]    ram_dataOut;

  modport slave (
    input  in_valid, in_data, ram_dataOut,
    output in_ready, ram_wEn, ram_addr, ram_dataIn
  );

  modport master (
    output in_valid, in_data, ram_dataOut,
    input  in_ready, ram_wEn, ram_addr, ram_dataIn
  );

endinterface

// File: rtl/ram_loader_byte_packer.sv
// byte_packer: assembles a little-endian word from a byte stream.
//   clk, reset_n - clock, asynchronous active-low reset
//   clear        - return the byte index to lane 0
//   take         - a byte is accepted this cycle
//   in_data      - accepted byte
//   word         - assembled word with the current byte already merged in
//   word_ready   - the byte taken this cycle completes the word
import ram_loader_pkg::*;

module byte_packer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  take,
  input  logic [7:0]            in_data,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_ready
);

  localparam int NB = bytes_of(DATA_WIDTH);
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [KW-1:0] LAST = KW'(NB - 1);

  logic [KW-1:0]         k;
  logic [DATA_WIDTH-1:0] acc;

  // The merged view lets the caller capture the complete word on the same
  // edge that accepts the last byte.
  always_comb begin
    word = acc;
    for (int i = 0; i < NB; i++) begin
      if (k == KW'(i)) word[LANE_W*i +: LANE_W] = in_data;
    end
    word_ready = take && (k == LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k <= '0;
    end else if (clear) begin
      k <= '0;
    end else if (take) begin
      k <= word_ready ? '0 : k + KW'(1);
    end
  end

  // Stale lanes need no clearing: every lane is overwritten before use.
  always_ff @(posedge clk) begin
    if (take) acc <= word;
  end

endmodule

// File: rtl/ram_loader.sv
// ram_loader: loads a byte stream into consecutive RAM words, then reads the
// range back and compares the readback sum with the write checksum.
//   clk, reset_n          - clock, asynchronous active-low reset
//   start                 - begin a load (honoured only when idle)
//   base_addr, word_count - load range, latched on start
//   bus                   - byte stream + RAM port (ram_loader_if.slave)
//   busy, done            - activity flag, one-cycle completion pulse
//   error                 - sticky range/verify failure, cleared on start
//   checksum              - sum of all words written
import ram_loader_pkg::*;

module ram_loader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int DEPTH         = 4096
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   word_count,
  ram_loader_if.slave              bus,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [DATA_WIDTH-1:0]    checksum
);

  localparam int CW = ADDRESS_WIDTH + 1;
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t state, state_nxt;

  logic [ADDRESS_WIDTH-1:0] base_q;
  logic [CW-1:0]            wc_q, n_q, rd_idx;
  logic [DATA_WIDTH-1:0]    rb_sum, packed_word, din_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic                     in_ready_q, wen_q;
  logic                     take, word_ready;
  logic                     start_acc, zero_cnt, over_range;
  logic                     vld_p0, last_p0, vld_p1, last_p1;

  assign bus.in_ready   = in_ready_q;
  assign bus.ram_wEn    = wen_q;
  assign bus.ram_addr   = addr_q;
  assign bus.ram_dataIn = din_q;

  assign take       = bus.in_valid && in_ready_q;
  assign start_acc  = (state == IDLE) && start;
  assign zero_cnt   = (word_count == '0);
  assign over_range = ({1'b0, base_addr} + word_count) > DEPTH_C;

  byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (start_acc),
    .take       (take),
    .in_data    (bus.in_data),
    .word       (packed_word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (zero_cnt || over_range) ? DONE : LOAD;
      LOAD:    if (word_ready) state_nxt = WRITE;
      WRITE:   state_nxt = (n_q + ONE == wc_q) ? VERIFY : LOAD;
      VERIFY:  if (last_p1) state_nxt = CHECK;
      CHECK:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Flags are decoded from the next state so the registered copies line up
  // exactly with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready_q <= 1'b0;
      wen_q      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      in_ready_q <= (state_nxt == LOAD);
      wen_q      <= (state_nxt == WRITE);
      busy       <= (state_nxt != IDLE);
      done       <= (state_nxt == DONE);
    end
  end

  // p0: readback address on the RAM port this cycle
  assign vld_p0  = (state == VERIFY) && (rd_idx < wc_q);
  assign last_p0 = vld_p0 && (rd_idx + ONE == wc_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_q      <= '0;
      rd_idx   <= '0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      error    <= 1'b0;
      checksum <= '0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      vld_p1  <= vld_p0;
      last_p1 <= last_p0;
      if (start_acc) begin
        n_q      <= '0;
        checksum <= '0;
        error    <= !zero_cnt && over_range;
      end
      if (word_ready) begin
        addr_q <= base_q + n_q[ADDRESS_WIDTH-1:0];
        din_q  <= packed_word;
      end
      if (state == WRITE) begin
        checksum <= checksum + din_q;
        n_q      <= n_q + ONE;
        rd_idx   <= '0;
        addr_q   <= base_q;
      end
      // Hold the last address rather than step past the end of the range.
      if (vld_p0) begin
        rd_idx <= rd_idx + ONE;
        if (!last_p0) addr_q <= addr_q + ADDRESS_WIDTH'(1);
      end
      if (state == CHECK && rb_sum != checksum) error <= 1'b1;
    end
  end

  // p1: registered read data returns and is accumulated
  always_ff @(posedge clk) begin
    if (start_acc) begin
      base_q <= base_addr;
      wc_q   <= word_count;
      rb_sum <= '0;
    end else if (vld_p1) begin
      rb_sum <= rb_sum + bus.ram_dataOut;
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
module tb_ram_loader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [11:0] base_addr;
  logic [12:0] word_count;
  logic        busy, done, error;
  logic [31:0] checksum;

  ram_loader_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12)) bus ();

  ram_loader #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12), .DEPTH(4096)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .checksum   (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  pat [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  logic [43:0] exp_q [$];
  logic [43:0] act_q [$];
  logic [31:0] exp_sum;

  // RAM model with optional readback corruption of one word
  logic [31:0] mem [4096];
  logic        flip;
  always @(posedge clk) begin
    if (bus.ram_wEn) mem[bus.ram_addr] <= bus.ram_dataIn;
    bus.ram_dataOut <= mem[bus.ram_addr] ^ {31'd0, (flip && bus.ram_addr == 12'h011)};
  end

  // Monitor: samples just after each active edge
  int wen_cnt, rdy_cnt, overlap, rdy_low_win, wen_win;
  bit win;
  always @(posedge clk) begin
    #1;
    if (bus.ram_wEn) begin
      act_q.push_back({bus.ram_addr, bus.ram_dataIn});
      wen_cnt++;
    end
    if (bus.in_ready) rdy_cnt++;
    if (bus.in_ready && bus.ram_wEn) overlap++;
    if (win) begin
      if (!bus.in_ready) rdy_low_win++;
      if (bus.ram_wEn) wen_win++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_sb();
    exp_q.delete();
    act_q.delete();
    exp_sum = '0;
    wen_cnt = 0; rdy_cnt = 0; rdy_low_win = 0; wen_win = 0;
  endtask

  task automatic do_start(input logic [11:0] b, input logic [12:0] wc);
    base_addr = b; word_count = wc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called on a negedge; returns on the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_vec++; n_err++;
      $display("FAIL byte_accept: in_ready=%0b after %0d cycles, required 1", bus.in_ready, t);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Drives nw words of the 11..88 pattern and records the expected writes.
  task automatic send_words(input logic [11:0] b, input int nw, input int gap);
    logic [31:0] w;
    for (int i = 0; i < nw; i++) begin
      w = {pat[(4*i+3)%8], pat[(4*i+2)%8], pat[(4*i+1)%8], pat[(4*i)%8]};
      exp_q.push_back({b + 12'(i), w});
      exp_sum += w;
      for (int j = 0; j < 4; j++) begin
        if (gap > 0 && (i > 0 || j > 0)) repeat (gap) @(negedge clk);
        send_byte(pat[(4*i+j)%8]);
      end
    end
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int t = 0; t < 300 && !seen; t++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_vec++;
    if ({bus.in_ready, bus.ram_wEn, busy, done, error} !== 5'b0 ||
        bus.ram_addr !== 12'h0 || bus.ram_dataIn !== 32'h0 || checksum !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state: rdy=%0b wen=%0b busy=%0b done=%0b err=%0b addr=%h din=%h sum=%h, required all 0",
               bus.in_ready, bus.ram_wEn, busy, done, error, bus.ram_addr, bus.ram_dataIn, checksum);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic(input int gap, input bit corrupt);
    bit seen;
    logic [43:0] a, e;
    clear_sb();
    flip = corrupt;
    do_start(12'h010, 13'd2);
    win = 1'b1;
    send_words(12'h010, 2, gap);
    win = 1'b0;
    wait_done(seen);
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL load_done: done never seen (gap=%0d)", gap); end
    n_vec++;
    if (error !== corrupt) begin
      n_err++; $display("FAIL load_error: error=%0b required %0b (gap=%0d)", error, corrupt, gap);
    end
    n_vec++;
    if (checksum !== 32'hCCAA8866) begin
      n_err++; $display("FAIL load_checksum: got %h required ccaa8866", checksum);
    end
    n_vec++;
    if (act_q.size() != 2) begin
      n_err++; $display("FAIL load_write_count: got %0d required 2", act_q.size());
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      n_vec++;
      if (a !== e) begin n_err++; $display("FAIL load_write: got %h@%h required %h@%h", a[31:0], a[43:32], e[31:0], e[43:32]); end
    end
    if (gap > 0) begin
      n_vec++;
      if (rdy_low_win != 2 || wen_win != 2) begin
        n_err++; $display("FAIL gap_ready_low: in_ready low %0d cycles, writes %0d, required 2 and 2", rdy_low_win, wen_win);
      end
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL done_pulse: done=%0b busy=%0b one cycle later, required 0 0", done, busy);
    end
    flip = 1'b0;
  endtask

  task automatic test_zero_count();
    clear_sb();
    do_start(12'h100, 13'd0);
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL zero_done: done=%0b busy=%0b in DONE, required 1 1", done, busy);
    end
    n_vec++;
    if (checksum !== 32'h0 || error !== 1'b0) begin
      n_err++; $display("FAIL zero_status: checksum=%h error=%0b, required 0 0", checksum, error);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0 || wen_cnt != 0) begin
      n_err++; $display("FAIL zero_after: done=%0b busy=%0b writes=%0d, required 0 0 0", done, busy, wen_cnt);
    end
  endtask

  task automatic test_bounds();
    bit seen;
    logic [43:0] a, e;
    clear_sb();
    do_start(12'hFFF, 13'd2);
    wait_done(seen);
    n_vec++;
    if (!seen || error !== 1'b1) begin
      n_err++; $display("FAIL bounds_error: done_seen=%0b error=%0b, required 1 1", seen, error);
    end
    n_vec++;
    if (wen_cnt != 0 || rdy_cnt != 0) begin
      n_err++; $display("FAIL bounds_quiet: writes=%0d ready_cycles=%0d, required 0 0", wen_cnt, rdy_cnt);
    end
    // Range ending exactly at the last word is legal.
    @(negedge clk);
    clear_sb();
    do_start(12'hFFE, 13'd2);
    send_words(12'hFFE, 2, 0);
    wait_done(seen);
    n_vec++;
    if (!seen || error !== 1'b0 || checksum !== exp_sum) begin
      n_err++; $display("FAIL bounds_edge: done_seen=%0b error=%0b sum=%h, required 1 0 %h", seen, error, checksum, exp_sum);
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      n_vec++;
      if (a !== e) begin n_err++; $display("FAIL bounds_edge_write: got %h@%h required %h@%h", a[31:0], a[43:32], e[31:0], e[43:32]); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_load();
    bit seen;
    logic [43:0] a, e;
    clear_sb();
    do_start(12'h010, 13'd2);
    send_words(12'h010, 1, 0);
    send_byte(8'h55);
    send_byte(8'h66);
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.in_ready, bus.ram_wEn, busy, done, error} !== 5'b0 ||
        bus.ram_addr !== 12'h0 || bus.ram_dataIn !== 32'h0 || checksum !== 32'h0) begin
      n_err++;
      $display("FAIL midreset_state: rdy=%0b wen=%0b busy=%0b err=%0b addr=%h din=%h sum=%h, required all 0",
               bus.in_ready, bus.ram_wEn, busy, error, bus.ram_addr, bus.ram_dataIn, checksum);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (act_q.size() != 1) begin
      n_err++; $display("FAIL midreset_writes: got %0d writes, required 1 (partial word dropped)", act_q.size());
    end
    clear_sb();
    do_start(12'h020, 13'd2);
    send_words(12'h020, 2, 0);
    wait_done(seen);
    n_vec++;
    if (!seen || error !== 1'b0 || checksum !== 32'hCCAA8866) begin
      n_err++; $display("FAIL midreset_reload: done_seen=%0b error=%0b sum=%h, required 1 0 ccaa8866", seen, error, checksum);
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      n_vec++;
      if (a !== e) begin n_err++; $display("FAIL midreset_write: got %h@%h required %h@%h", a[31:0], a[43:32], e[31:0], e[43:32]); end
    end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    bit seen;
    clear_sb();
    do_start(12'h040, 13'd1);
    do_start(12'h000, 13'd0);
    send_words(12'h040, 1, 0);
    wait_done(seen);
    n_vec++;
    if (!seen || wen_cnt != 1 || checksum !== 32'h44332211 || error !== 1'b0) begin
      n_err++; $display("FAIL busy_start: done_seen=%0b writes=%0d sum=%h err=%0b, required 1 1 44332211 0", seen, wen_cnt, checksum, error);
    end
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    word_count = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    flip = 1'b0;
    win = 1'b0;
    overlap = 0;
    clear_sb();

    test_reset();
    test_basic(0, 1'b0);
    test_basic(3, 1'b0);
    test_zero_count();
    test_bounds();
    test_basic(0, 1'b1);
    test_reset_mid_load();
    test_start_while_busy();

    n_vec++;
    if (overlap != 0) begin
      n_err++; $display("FAIL ready_wen_overlap: %0d cycles with both high, required 0", overlap);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
